// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - write handshake port of the seven-segment scan controller
interface seg_scan_ctrl_if;
    logic        WR_VALID;
    logic [15:0] WR_DATA;
    logic        WR_READY;

    modport master (output WR_VALID, output WR_DATA, input WR_READY);
    modport slave  (input WR_VALID, input WR_DATA, output WR_READY);
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit seven-segment scan scheduler with frame-synchronous updates
module seg_scan_ctrl #(
    parameter int SCAN_DIV     = 12000,
    parameter int BLANK_CYCLES = 600
) (
    input  logic           CLK,
    input  logic           RST,
    seg_scan_ctrl_if.slave wr,
    input  logic [3:0]     DIGIT_EN,
    output logic [6:0]     SEG,
    output logic [3:0]     COMM,
    output logic           FRAME_TICK
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [1:0]    dig;
    logic [15:0]   disp_reg;
    logic [15:0]   pend_reg;
    logic          pend;

    logic          slot_end;
    logic          frame_end;
    logic          accept;
    logic          lit;
    logic [3:0]    nibble;

    function automatic logic [6:0] hexdec(input logic [3:0] h);
        case (h)
            4'h0: hexdec = 7'h3F;
            4'h1: hexdec = 7'h06;
            4'h2: hexdec = 7'h5B;
            4'h3: hexdec = 7'h4F;
            4'h4: hexdec = 7'h66;
            4'h5: hexdec = 7'h6D;
            4'h6: hexdec = 7'h7D;
            4'h7: hexdec = 7'h07;
            4'h8: hexdec = 7'h7F;
            4'h9: hexdec = 7'h6F;
            4'hA: hexdec = 7'h77;
            4'hB: hexdec = 7'h7C;
            4'hC: hexdec = 7'h39;
            4'hD: hexdec = 7'h5E;
            4'hE: hexdec = 7'h79;
            default: hexdec = 7'h71;
        endcase
    endfunction

    assign slot_end    = (cnt == CNT_LAST);
    assign frame_end   = slot_end && (dig == 2'd3);
    assign accept      = wr.WR_VALID && !pend;
    assign lit         = (cnt >= CNT_BLANK) && DIGIT_EN[dig];
    assign nibble      = disp_reg[{dig, 2'b00} +: 4];
    assign wr.WR_READY = ~pend;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            dig        <= 2'd0;
            disp_reg   <= 16'h0000;
            pend_reg   <= 16'h0000;
            pend       <= 1'b0;
            SEG        <= 7'h00;
            COMM       <= 4'b1111;
            FRAME_TICK <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                dig <= dig + 2'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            SEG        <= lit ? hexdec(nibble) : 7'h00;
            COMM       <= lit ? ~(4'b0001 << dig) : 4'b1111;
            FRAME_TICK <= frame_end;

            // A write landing on the boundary sees pend==0 there, so it waits a full frame.
            if (frame_end && pend) begin
                disp_reg <= pend_reg;
                pend     <= 1'b0;
            end else if (accept) begin
                pend_reg <= wr.WR_DATA;
                pend     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - scoreboard bench for seg_scan_ctrl against a cycle-indexed display model
module tb_seg_scan_ctrl;
    localparam int SD    = 8;
    localparam int BL    = 2;
    localparam int FRAME = 4 * SD;

    logic       CLK;
    logic       RST;
    logic [3:0] DIGIT_EN;
    logic [6:0] SEG;
    logic [3:0] COMM;
    logic       FRAME_TICK;

    seg_scan_ctrl_if wr();

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .wr         (wr.slave),
        .DIGIT_EN   (DIGIT_EN),
        .SEG        (SEG),
        .COMM       (COMM),
        .FRAME_TICK (FRAME_TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model: k counts cycles since reset release; slot, digit and frame position are k mod/div arithmetic.
    int          k = 0;
    logic [15:0] m_disp = 16'h0;
    logic [15:0] m_pval = 16'h0;
    bit          m_pend = 1'b0;
    logic [12:0] exp_q [$];

    always @(posedge CLK) begin
        int         slot;
        int         d;
        bit         on;
        logic [6:0] e_seg;
        logic [3:0] e_comm;
        bit         e_tick;
        if (RST) begin
            k      = 0;
            m_disp = 16'h0;
            m_pend = 1'b0;
            exp_q.push_back({7'h00, 4'b1111, 1'b0, 1'b1});
        end else begin
            slot   = k % SD;
            d      = (k / SD) % 4;
            on     = (slot >= BL) && DIGIT_EN[d];
            e_seg  = on ? hex_tab[(m_disp >> (4 * d)) & 16'hF] : 7'h00;
            e_comm = on ? ~(4'b0001 << d) : 4'b1111;
            e_tick = ((k % FRAME) == FRAME - 1);
            if (e_tick && m_pend) begin
                m_disp = m_pval;
                m_pend = 1'b0;
            end else if (wr.WR_VALID && !m_pend) begin
                m_pval = wr.WR_DATA;
                m_pend = 1'b1;
            end
            k++;
            exp_q.push_back({e_seg, e_comm, e_tick, !m_pend});
        end
    end

    always @(negedge CLK) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({SEG, COMM, FRAME_TICK, wr.WR_READY} !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got seg=%h comm=%b tick=%b rdy=%b want seg=%h comm=%b tick=%b rdy=%b",
                         $time, SEG, COMM, FRAME_TICK, wr.WR_READY, e[12:6], e[5:2], e[1], e[0]);
            end
            checks++;
            if ($countones(~COMM) > 1) begin
                failures++;
                $display("FAIL comm_onehot t=%0t got comm=%b want at most one low", $time, COMM);
            end
        end
    end

    task automatic do_write(input logic [15:0] d);
        int n = 0;
        wr.WR_VALID = 1'b1;
        wr.WR_DATA  = d;
        while (!wr.WR_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL wr_timeout got ready=%b after %0d cycles want ready=1", wr.WR_READY, n);
        end
        @(negedge CLK);
        wr.WR_VALID = 1'b0;
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while ((k % FRAME) != p && n < 100) begin
            @(negedge CLK);
            n++;
        end
    endtask

    initial begin
        RST         = 1'b1;
        wr.WR_VALID = 1'b0;
        wr.WR_DATA  = 16'h0;
        DIGIT_EN    = 4'hF;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);

        wait_phase(0);
        do_write(16'h1234);
        repeat (70) @(negedge CLK);

        do_write(16'hAAAA);
        do_write(16'hFFFF);
        repeat (100) @(negedge CLK);

        DIGIT_EN = 4'b0101;
        do_write(16'h9876);
        repeat (100) @(negedge CLK);
        DIGIT_EN = 4'hF;

        wait_phase(0);
        do_write(16'h5555);
        wait_phase(SD * 2 + 4);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (70) @(negedge CLK);

        wait_phase(FRAME - 1);
        wr.WR_VALID = 1'b1;
        wr.WR_DATA  = 16'hC0DE;
        @(negedge CLK);
        wr.WR_VALID = 1'b0;
        repeat (80) @(negedge CLK);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 5) do_write(16'($urandom));
            else if (r < 8) DIGIT_EN = 4'($urandom);
            else if (r == 8) begin
                RST = 1'b1;
                @(negedge CLK);
                RST = 1'b0;
            end
            repeat ($urandom_range(1, 40)) @(negedge CLK);
        end

        repeat (10) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish want finish before time limit");
        $fatal(1);
    end
endmodule
